// File: rtl/reset_seq_ctrl.sv
// reset_seq_ctrl: sequences reset release for NUM_DOMAINS downstream reset
// domains. Raw reset, software requests and watchdog expiry all lead to a
// common hold period, followed by in-order domain release with a fixed gap.
module reset_seq_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int NUM_DOMAINS    = 3,
  parameter int MIN_ASSERT_CYC = 16,
  parameter int RELEASE_GAP    = 8,
  parameter int CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_rst_req,
  input  logic                   wdt_expire,
  output logic [NUM_DOMAINS-1:0] dom_rst_out,
  output logic                   rst_busy,
  output logic                   rst_done,
  output logic [1:0]             rst_cause
);

  // The FSM's SYNC state bit acts as the final synchroniser stage: it leaves
  // SYNC on the same edge a full SYNC_STAGES-deep chain output would clear.
  localparam int SYNC_W = SYNC_STAGES - 1;
  localparam int IDX_W  = $clog2(NUM_DOMAINS + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_ASSERT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RELEASE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_END   = IDX_W'(NUM_DOMAINS);

  typedef enum logic [2:0] {
    SYNC,
    HOLD,
    RELEASE,
    DONE,
    IDLE
  } state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_W-1:0]      sync_reg;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [NUM_DOMAINS-1:0] dom_reg, dom_next;
  logic [1:0]             cause_reg, cause_next;
  logic [NUM_DOMAINS-1:0] clr_sel;
  logic                   sync_released;
  logic                   req;

  // Release synchroniser: set asynchronously, shifts in zeros once released.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= SYNC_W'({sync_reg, 1'b0});
    end
  end

  assign sync_released = ~sync_reg[SYNC_W-1];
  assign req           = sw_rst_req | wdt_expire;

  // One-hot decode of the domain selected for release by the current index;
  // indices past the last domain select nothing.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_clr_sel
      assign clr_sel[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Sequencer state, counters, domain resets and cause register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg <= SYNC;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      dom_reg   <= '1;
      cause_reg <= 2'b00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      dom_reg   <= dom_next;
      cause_reg <= cause_next;
    end
  end

  // Next-state and output logic; a request outside SYNC overrides everything.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    dom_next   = dom_reg;
    cause_next = cause_reg;
    rst_busy   = 1'b1;
    rst_done   = 1'b0;

    case (state_reg)
      SYNC: begin
        if (sync_released) begin
          state_next = HOLD;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end

      HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          dom_next[0] = 1'b0;
          state_next  = RELEASE;
          cnt_next    = '0;
          idx_next    = IDX_W'(1);
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      RELEASE: begin
        // Once the index runs past the last domain, busy drops on the next
        // edge together with the done pulse (also covers NUM_DOMAINS = 1).
        if (idx_reg == IDX_END) begin
          state_next = DONE;
        end else if (cnt_reg == GAP_LAST) begin
          dom_next = dom_reg & ~clr_sel;
          idx_next = idx_reg + IDX_W'(1);
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      DONE: begin
        rst_busy   = 1'b0;
        rst_done   = ~req;
        state_next = IDLE;
      end

      IDLE: begin
        rst_busy = 1'b0;
      end

      default: begin
        state_next = SYNC;
      end
    endcase

    if (req && (state_reg != SYNC)) begin
      dom_next   = '1;
      state_next = HOLD;
      cnt_next   = '0;
      idx_next   = '0;
      cause_next = wdt_expire ? 2'b10 : 2'b01;
    end
  end

  assign dom_rst_out = dom_reg;
  assign rst_cause   = cause_reg;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Self-checking bench for reset_seq_ctrl: a default instance (3 domains) and a
// minimal instance (1 domain, 3 sync stages, 1-cycle hold), both compared
// every cycle against an edge-arithmetic reference model.
module tb_reset_seq_ctrl;

  localparam int NA = 3, SA = 2, MA = 16, GA = 8;
  localparam int NB = 1, SB = 3, MB = 1,  GB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, sw_a, wdt_a;
  logic [NA-1:0] dom_a;
  logic          busy_a, done_a;
  logic [1:0]    cause_a;

  logic          rst_b, sw_b, wdt_b;
  logic [NB-1:0] dom_b;
  logic          busy_b, done_b;
  logic [1:0]    cause_b;

  reset_seq_ctrl #(
    .SYNC_STAGES(SA), .NUM_DOMAINS(NA), .MIN_ASSERT_CYC(MA),
    .RELEASE_GAP(GA), .CNT_W(8)
  ) u_a (
    .clk(clk), .rst_n(rst_a), .sw_rst_req(sw_a), .wdt_expire(wdt_a),
    .dom_rst_out(dom_a), .rst_busy(busy_a), .rst_done(done_a),
    .rst_cause(cause_a)
  );

  reset_seq_ctrl #(
    .SYNC_STAGES(SB), .NUM_DOMAINS(NB), .MIN_ASSERT_CYC(MB),
    .RELEASE_GAP(GB), .CNT_W(8)
  ) u_b (
    .clk(clk), .rst_n(rst_b), .sw_rst_req(sw_b), .wdt_expire(wdt_b),
    .dom_rst_out(dom_b), .rst_busy(busy_b), .rst_done(done_b),
    .rst_cause(cause_b)
  );

  // Reference model: each instance is described by the edge h at which its
  // hold period starts; everything else follows by arithmetic from h.
  int         edge_n;
  int         h_a, h_b;
  logic [1:0] cause_ma, cause_mb;
  int         n_checks, n_pass;

  function automatic logic [7:0] exp_dom(int n, int mn, int gap, int h, int e, logic rhi);
    logic [7:0] d;
    d = '0;
    for (int k = 0; k < n; k++) d[k] = rhi || (e < h + mn + gap * k);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, obs, exp);
  endtask

  task automatic check_all(input logic req_a, input logic req_b);
    int   last_a, last_b;
    logic eb, ed;
    last_a = h_a + MA + GA * (NA - 1);
    last_b = h_b + MB + GB * (NB - 1);

    chk("a_dom", {5'b0, dom_a}, exp_dom(NA, MA, GA, h_a, edge_n, rst_a));
    eb = rst_a || (edge_n <= last_a);
    chk("a_busy", {7'b0, busy_a}, {7'b0, eb});
    ed = !rst_a && (edge_n == last_a + 1) && !req_a;
    chk("a_done", {7'b0, done_a}, {7'b0, ed});
    chk("a_cause", {6'b0, cause_a}, {6'b0, (rst_a ? 2'b00 : cause_ma)});

    chk("b_dom", {7'b0, dom_b}, exp_dom(NB, MB, GB, h_b, edge_n, rst_b));
    eb = rst_b || (edge_n <= last_b);
    chk("b_busy", {7'b0, busy_b}, {7'b0, eb});
    ed = !rst_b && (edge_n == last_b + 1) && !req_b;
    chk("b_done", {7'b0, done_b}, {7'b0, ed});
    chk("b_cause", {6'b0, cause_b}, {6'b0, (rst_b ? 2'b00 : cause_mb)});
  endtask

  // One clock cycle: drive requests after the falling edge, check, then let
  // the model absorb whatever the rising edge sampled.
  task automatic cycle(input logic swa, input logic wdta, input logic swb);
    sw_a  = swa;
    wdt_a = wdta;
    sw_b  = swb;
    #1;
    check_all(swa | wdta, swb);
    @(posedge clk);
    edge_n++;
    if (!rst_a && (swa | wdta) && edge_n > h_a) begin
      h_a      = edge_n;
      cause_ma = wdta ? 2'b10 : 2'b01;
      $display("a: request accepted edge=%0d sw=%0b wdt=%0b", edge_n, swa, wdta);
    end
    if (!rst_b && swb && edge_n > h_b) begin
      h_b      = edge_n;
      cause_mb = 2'b01;
      $display("b: request accepted edge=%0d", edge_n);
    end
    @(negedge clk);
  endtask

  task automatic assert_rst_a();
    rst_a    = 1'b1;
    cause_ma = 2'b00;
    #1;
    $display("a: rst_n asserted mid-cycle after edge=%0d", edge_n);
    check_all(1'b0, 1'b0);
  endtask

  task automatic release_rst_a();
    rst_a = 1'b0;
    h_a   = edge_n + SA;
    $display("a: rst_n released after edge=%0d", edge_n);
  endtask

  initial begin
    rst_a = 1'b1; sw_a = 1'b0; wdt_a = 1'b0;
    rst_b = 1'b1; sw_b = 1'b0; wdt_b = 1'b0;
    edge_n = 0; h_a = 0; h_b = 0;
    cause_ma = 2'b00; cause_mb = 2'b00;
    n_checks = 0; n_pass = 0;

    @(negedge clk);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);

    // Power-on release of both instances; b sees requests while still in SYNC.
    rst_a = 1'b0; h_a = edge_n + SA;
    rst_b = 1'b0; h_b = edge_n + SB;
    $display("power-on release after edge=%0d", edge_n);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    repeat (42) cycle(1'b0, 1'b0, 1'b0);

    // Software reset from IDLE.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (40) cycle(1'b0, 1'b0, 1'b0);

    // Simultaneous software and watchdog request: watchdog wins.
    cycle(1'b1, 1'b1, 1'b0);
    repeat (40) cycle(1'b0, 1'b0, 1'b0);

    // Watchdog two cycles after domain 0 released.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (17) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    repeat (40) cycle(1'b0, 1'b0, 1'b0);

    // Request landing in the DONE cycle suppresses the done pulse.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (33) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (40) cycle(1'b0, 1'b0, 1'b0);

    // Raw reset mid-HOLD, with a request ignored while it is asserted.
    cycle(1'b0, 1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    assert_rst_a();
    cycle(1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    release_rst_a();

    // Raw reset mid-RELEASE of the repeated power-on sequence.
    repeat (22) cycle(1'b0, 1'b0, 1'b0);
    assert_rst_a();
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    release_rst_a();
    repeat (40) cycle(1'b0, 1'b0, 1'b0);

    // Randomised request traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 9) == 0));
    end
    repeat (40) cycle(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
